// File: rtl/lstm_fixed_pkg.sv
// Fixed-point constants, activation selectors, FSM encoding and the saturation helper
// shared by the LSTM gate stages.
package lstm_fixed_pkg;

    localparam int unsigned QN       = 6;
    localparam int unsigned QM       = 11;
    localparam int unsigned BITWIDTH = QN + QM + 1;
    localparam int          ONE      = 1 << QM;
    localparam int          HALF     = 1 << (QM - 1);

    localparam int unsigned ACT_SIGMOID = 0;
    localparam int unsigned ACT_TANH    = 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } gate_state_e;

    // Clamp a wide signed value into the range of a w-bit two's-complement number.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/gate_activation_if.sv
// Bus between the dot-product engines, the gate activation stage and the cell-state update.
// The satCount status signal exists only when GATE_SATCOUNT_EN is defined.
interface gate_activation_if #(
    parameter int unsigned NROW     = 16,
    parameter int unsigned BITWIDTH = lstm_fixed_pkg::BITWIDTH
);

    localparam int unsigned LAYER_BITWIDTH = BITWIDTH * NROW;

    logic [LAYER_BITWIDTH-1:0] xProd;
    logic                      xReady;
    logic [LAYER_BITWIDTH-1:0] hProd;
    logic                      hReady;
    logic [LAYER_BITWIDTH-1:0] bias;
    logic [LAYER_BITWIDTH-1:0] gateOut;
    logic                      gateValid;
    logic                      busy;
    logic                      overrun;
`ifdef GATE_SATCOUNT_EN
    logic [15:0]               satCount;
`endif

    modport master (
        output xProd,
        output xReady,
        output hProd,
        output hReady,
        output bias,
        input  gateOut,
        input  gateValid,
        input  busy,
`ifdef GATE_SATCOUNT_EN
        input  satCount,
`endif
        input  overrun
    );

    modport slave (
        input  xProd,
        input  xReady,
        input  hProd,
        input  hReady,
        input  bias,
        output gateOut,
        output gateValid,
        output busy,
`ifdef GATE_SATCOUNT_EN
        output satCount,
`endif
        output overrun
    );

endinterface

// File: rtl/gate_act_unit.sv
// Per-element datapath: three-way sum with saturation, and the hard sigmoid / hard tanh
// activation selected by ACT_TYPE. Purely combinational.
module gate_act_unit #(
    parameter int unsigned QN       = lstm_fixed_pkg::QN,
    parameter int unsigned QM       = lstm_fixed_pkg::QM,
    parameter int unsigned ACT_TYPE = lstm_fixed_pkg::ACT_SIGMOID
) (
    input  logic signed [QN+QM:0] i_x,
    input  logic signed [QN+QM:0] i_h,
    input  logic signed [QN+QM:0] i_b,
    output logic signed [QN+QM:0] o_sum,
    output logic                  o_sat,
    input  logic signed [QN+QM:0] i_s,
    output logic signed [QN+QM:0] o_y
);
    import lstm_fixed_pkg::*;

    localparam int unsigned Bw = QN + QM + 1;

    typedef logic signed [Bw-1:0] elem_t;
    typedef logic signed [Bw+1:0] sum_t;
    typedef logic signed [Bw:0]   act_t;
    typedef logic signed [63:0]   wide_t;

    localparam act_t One  = act_t'(64'sd1 <<< QM);
    localparam act_t Half = act_t'(64'sd1 <<< (QM - 1));

    sum_t w_sum;
    act_t w_act;

    // Two guard bits make the three-operand sum exact before saturation.
    always_comb begin
        w_sum = sum_t'(i_x) + sum_t'(i_h) + sum_t'(i_b);
        o_sum = elem_t'(saturate(wide_t'(w_sum), Bw));
        o_sat = (saturate(wide_t'(w_sum), Bw) != wide_t'(w_sum));
    end

    if (ACT_TYPE == ACT_TANH) begin : g_tanh
        always_comb begin
            w_act = act_t'(i_s);
            if (w_act > One) begin
                w_act = One;
            end else if (w_act < -One) begin
                w_act = -One;
            end
            o_y = elem_t'(w_act);
        end
    end else begin : g_sigmoid
        always_comb begin
            w_act = act_t'(i_s >>> 2) + Half;
            if (w_act < act_t'(0)) begin
                w_act = act_t'(0);
            end else if (w_act > One) begin
                w_act = One;
            end
            o_y = elem_t'(w_act);
        end
    end

endmodule

// File: rtl/gate_activation.sv
// LSTM gate activation stage: captures W.x and U.h, then streams bias-add, saturation and
// activation one element per cycle. GATE_SATCOUNT_EN adds a saturation-event counter.
module gate_activation #(
    parameter int unsigned NROW     = 16,
    parameter int unsigned QN       = lstm_fixed_pkg::QN,
    parameter int unsigned QM       = lstm_fixed_pkg::QM,
    parameter int unsigned ACT_TYPE = lstm_fixed_pkg::ACT_SIGMOID
) (
    input logic              clk,
    input logic              reset,
    gate_activation_if.slave bus
);
    import lstm_fixed_pkg::*;

    localparam int unsigned Bw      = QN + QM + 1;
    localparam int unsigned LayerBw = Bw * NROW;
    localparam int unsigned IdxBw   = (NROW > 1) ? $clog2(NROW) : 1;
    localparam logic [IdxBw-1:0] LastIdx = IdxBw'(NROW - 1);

    typedef logic signed [Bw-1:0] elem_t;

    gate_state_e r_state;
    gate_state_e w_state_next;

    logic [LayerBw-1:0] r_x;
    logic [LayerBw-1:0] r_h;
    logic               r_x_got;
    logic               r_h_got;
    logic               w_x_got_next;
    logic               w_h_got_next;
    logic               w_capture_ok;
    logic               r_overrun;

    logic [IdxBw-1:0] r_idx;
    logic             r_fetch_done;
    logic             r_op_vld;
    logic [IdxBw-1:0] r_op_idx;
    elem_t            r_op_x;
    elem_t            r_op_h;
    elem_t            r_op_b;
    logic             r_s_vld;
    logic [IdxBw-1:0] r_s_idx;
    elem_t            r_s;
    logic             r_wr_last;
    elem_t            r_gate [NROW];

    elem_t              w_sum;
    elem_t              w_y;
    logic               w_sat;
    logic               w_busy;
    logic               w_valid;
    logic [LayerBw-1:0] w_gate_out;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_capture_ok = (r_state == StIdle) || (r_state == StWait);
        w_x_got_next = r_x_got | (w_capture_ok & bus.xReady);
        w_h_got_next = r_h_got | (w_capture_ok & bus.hReady);
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_x_got_next && w_h_got_next) begin
                    w_state_next = StRun;
                end else if (w_x_got_next || w_h_got_next) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (w_x_got_next && w_h_got_next) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (r_wr_last) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_busy  = (r_state == StRun) || (r_state == StDone);
        w_valid = (r_state == StDone);
    end

    // Capture is only open in IDLE/WAIT; pulses arriving while busy are dropped and flagged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_x       <= '0;
            r_h       <= '0;
            r_x_got   <= 1'b0;
            r_h_got   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_state == StDone) begin
                r_x_got <= 1'b0;
                r_h_got <= 1'b0;
            end else if (w_capture_ok) begin
                if (bus.xReady) begin
                    r_x     <= bus.xProd;
                    r_x_got <= 1'b1;
                end
                if (bus.hReady) begin
                    r_h     <= bus.hProd;
                    r_h_got <= 1'b1;
                end
            end
            if (!w_capture_ok && (bus.xReady || bus.hReady)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Operand fetch registers the selected element so the wide mux is off the adder path.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx        <= '0;
            r_fetch_done <= 1'b0;
            r_op_vld     <= 1'b0;
            r_op_idx     <= '0;
            r_op_x       <= '0;
            r_op_h       <= '0;
            r_op_b       <= '0;
        end else begin
            r_op_vld <= 1'b0;
            if (r_state == StRun && !r_fetch_done) begin
                r_op_x   <= elem_t'(r_x[r_idx*Bw +: Bw]);
                r_op_h   <= elem_t'(r_h[r_idx*Bw +: Bw]);
                r_op_b   <= elem_t'(bus.bias[r_idx*Bw +: Bw]);
                r_op_idx <= r_idx;
                r_op_vld <= 1'b1;
                if (r_idx == LastIdx) begin
                    r_idx        <= '0;
                    r_fetch_done <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
            if (r_state == StDone) begin
                r_idx        <= '0;
                r_fetch_done <= 1'b0;
            end
        end
    end

    gate_act_unit #(
        .QN       (QN),
        .QM       (QM),
        .ACT_TYPE (ACT_TYPE)
    ) u_act (
        .i_x   (r_op_x),
        .i_h   (r_op_h),
        .i_b   (r_op_b),
        .o_sum (w_sum),
        .o_sat (w_sat),
        .i_s   (r_s),
        .o_y   (w_y)
    );

    // Stage 1 holds the saturated sum, stage 2 writes the activated element.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s_vld   <= 1'b0;
            r_s_idx   <= '0;
            r_s       <= '0;
            r_wr_last <= 1'b0;
            for (int k = 0; k < int'(NROW); k++) begin
                r_gate[k] <= '0;
            end
        end else begin
            r_s_vld   <= r_op_vld;
            r_wr_last <= r_s_vld && (r_s_idx == LastIdx);
            if (r_op_vld) begin
                r_s     <= w_sum;
                r_s_idx <= r_op_idx;
            end
            if (r_s_vld) begin
                r_gate[r_s_idx] <= w_y;
            end
        end
    end

    for (genvar k = 0; k < int'(NROW); k++) begin : g_pack
        assign w_gate_out[k*Bw +: Bw] = r_gate[k];
    end

    assign bus.gateOut   = w_gate_out;
    assign bus.gateValid = w_valid;
    assign bus.busy      = w_busy;
    assign bus.overrun   = r_overrun;

`ifdef GATE_SATCOUNT_EN
    logic [15:0] r_sat_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sat_cnt <= '0;
        end else if (w_state_next == StRun && r_state != StRun) begin
            r_sat_cnt <= '0;
        end else if (r_op_vld && w_sat && r_sat_cnt != 16'hFFFF) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign bus.satCount = r_sat_cnt;
`else
    logic w_sat_unused;
    assign w_sat_unused = w_sat;
`endif

endmodule

// File: tb/tb_gate_activation.sv
// Directed bench for gate_activation: a sigmoid and a tanh instance share every stimulus
// vector; satCount is also checked when GATE_SATCOUNT_EN is defined.
module tb_gate_activation;
    import lstm_fixed_pkg::*;

    localparam int unsigned NRow = 4;
    localparam int unsigned Bw   = 18;
    localparam int unsigned Lw   = NRow * Bw;
    localparam int          Lat  = NRow + 3;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    gate_activation_if #(.NROW(NRow), .BITWIDTH(Bw)) bus_sig ();
    gate_activation_if #(.NROW(NRow), .BITWIDTH(Bw)) bus_tanh ();

    gate_activation #(
        .NROW     (NRow),
        .QN       (6),
        .QM       (11),
        .ACT_TYPE (ACT_SIGMOID)
    ) u_dut_sig (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_sig.slave)
    );

    gate_activation #(
        .NROW     (NRow),
        .QN       (6),
        .QM       (11),
        .ACT_TYPE (ACT_TANH)
    ) u_dut_tanh (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_tanh.slave)
    );

    // Vector A: sums 2048, -8192, 8192 and a positive-saturating element.
    int xa [NRow] = '{1024, -4096, 4096, 131071};
    int ha [NRow] = '{1024, -4096, 4096, 131071};
    int ba [NRow] = '{0, 0, 0, 131071};
    int sig_a [NRow]  = '{1536, 0, 2048, 2048};
    int tanh_a [NRow] = '{2048, -2048, 2048, 2048};
    // Vector B: sums -3000, 500, 3000 and a negative-saturating element.
    int xb [NRow] = '{-3000, 500, 3000, -131072};
    int hb [NRow] = '{0, 0, 0, -131072};
    int bb [NRow] = '{0, 0, 0, -131072};
    int sig_b [NRow]  = '{274, 1149, 1774, 0};
    int tanh_b [NRow] = '{-2048, 500, 2048, -2048};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [Lw-1:0] pack_vec(input int v [NRow]);
        logic [Lw-1:0] r;
        int            e;
        r = '0;
        for (int k = 0; k < int'(NRow); k++) begin
            e = v[k];
            r[k*Bw +: Bw] = e[Bw-1:0];
        end
        return r;
    endfunction

    task automatic set_bias(input logic [Lw-1:0] b);
        bus_sig.bias  = b;
        bus_tanh.bias = b;
    endtask

    // Called at a negedge; the pulse is sampled at the next posedge and removed after it.
    task automatic pulse(input logic xr, input logic [Lw-1:0] xv,
                         input logic hr, input logic [Lw-1:0] hv);
        bus_sig.xReady  = xr;
        bus_tanh.xReady = xr;
        bus_sig.hReady  = hr;
        bus_tanh.hReady = hr;
        if (xr) begin
            bus_sig.xProd  = xv;
            bus_tanh.xProd = xv;
        end
        if (hr) begin
            bus_sig.hProd  = hv;
            bus_tanh.hProd = hv;
        end
        @(negedge clk);
        bus_sig.xReady  = 1'b0;
        bus_tanh.xReady = 1'b0;
        bus_sig.hReady  = 1'b0;
        bus_tanh.hReady = 1'b0;
    endtask

    // n counts posedges after the second capture edge; bounded so a missing pulse fails.
    task automatic wait_valid(input string tag, input int n0);
        int n;
        n = n0;
        while (bus_sig.gateValid !== 1'b1 && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, Lat);
        check({tag, " tanh valid"}, bus_tanh.gateValid, 1);
    endtask

    task automatic check_vec(input string tag, input int se [NRow], input int te [NRow],
                             input int exp_sat);
        for (int k = 0; k < int'(NRow); k++) begin
            check($sformatf("%s sig[%0d]", tag, k), $signed(bus_sig.gateOut[k*Bw +: Bw]), se[k]);
            check($sformatf("%s tanh[%0d]", tag, k), $signed(bus_tanh.gateOut[k*Bw +: Bw]),
                  te[k]);
        end
`ifdef GATE_SATCOUNT_EN
        check({tag, " sig satCount"}, bus_sig.satCount, exp_sat);
        check({tag, " tanh satCount"}, bus_tanh.satCount, exp_sat);
`else
        if (exp_sat < 0) begin
            check({tag, " sat arg"}, exp_sat, 0);
        end
`endif
    endtask

    initial begin
        int seen;
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b0;
        bus_sig.xProd   = '0;
        bus_sig.hProd   = '0;
        bus_sig.bias    = '0;
        bus_sig.xReady  = 1'b0;
        bus_sig.hReady  = 1'b0;
        bus_tanh.xProd  = '0;
        bus_tanh.hProd  = '0;
        bus_tanh.bias   = '0;
        bus_tanh.xReady = 1'b0;
        bus_tanh.hReady = 1'b0;

        repeat (3) @(negedge clk);
        check("rst gateOut", |bus_sig.gateOut, 0);
        check("rst gateValid", bus_sig.gateValid, 0);
        check("rst busy", bus_sig.busy, 0);
        check("rst overrun", bus_sig.overrun, 0);
        reset = 1'b1;
        @(negedge clk);

        // hReady five cycles before xReady.
        set_bias(pack_vec(ba));
        pulse(1'b0, '0, 1'b1, pack_vec(ha));
        check("wait busy", bus_sig.busy, 0);
        repeat (4) @(negedge clk);
        pulse(1'b1, pack_vec(xa), 1'b0, '0);
        wait_valid("t1", 0);
        check("t1 busy in done", bus_sig.busy, 1);
        check_vec("t1", sig_a, tanh_a, 1);
        @(negedge clk);
        check("t1 valid one-shot", bus_sig.gateValid, 0);
        check("t1 idle busy", bus_sig.busy, 0);
        check("t1 hold sig[0]", $signed(bus_sig.gateOut[0 +: Bw]), 1536);

        // Both ready pulses in the same cycle; old elements persist until rewritten.
        set_bias(pack_vec(bb));
        pulse(1'b1, pack_vec(xb), 1'b1, pack_vec(hb));
        repeat (4) @(negedge clk);
        check("t2 new sig[0]", $signed(bus_sig.gateOut[0 +: Bw]), 274);
        check("t2 old sig[3]", $signed(bus_sig.gateOut[3*Bw +: Bw]), 2048);
        wait_valid("t2", 4);
        check_vec("t2", sig_b, tanh_b, 1);
        @(negedge clk);
        check("t2 valid one-shot", bus_sig.gateValid, 0);

        // Repeated xReady in WAIT: last capture wins, no overrun.
        pulse(1'b1, pack_vec(xa), 1'b0, '0);
        pulse(1'b1, pack_vec(xb), 1'b0, '0);
        pulse(1'b0, '0, 1'b1, pack_vec(hb));
        wait_valid("t3", 0);
        check_vec("t3", sig_b, tanh_b, 1);
        check("t3 overrun", bus_sig.overrun, 0);
        @(negedge clk);

        // xReady during RUN is dropped and sets sticky overrun.
        set_bias(pack_vec(ba));
        pulse(1'b1, pack_vec(xa), 1'b1, pack_vec(ha));
        repeat (2) @(negedge clk);
        pulse(1'b1, pack_vec(xb), 1'b0, '0);
        check("t4 overrun set", bus_sig.overrun, 1);
        wait_valid("t4", 3);
        check_vec("t4", sig_a, tanh_a, 1);
        repeat (2) @(negedge clk);
        check("t4 overrun sticky", bus_sig.overrun, 1);
        check("t4 idle busy", bus_sig.busy, 0);

        // Reset in the middle of RUN abandons the vector.
        set_bias(pack_vec(bb));
        pulse(1'b1, pack_vec(xb), 1'b1, pack_vec(hb));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t5 rst gateOut", |bus_sig.gateOut, 0);
        check("t5 rst gateValid", bus_sig.gateValid, 0);
        check("t5 rst busy", bus_sig.busy, 0);
        check("t5 rst overrun", bus_sig.overrun, 0);
        reset = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus_sig.gateValid === 1'b1) seen++;
        end
        check("t5 no valid after reset", seen, 0);
        set_bias(pack_vec(ba));
        pulse(1'b1, pack_vec(xa), 1'b1, pack_vec(ha));
        wait_valid("t5", 0);
        check_vec("t5", sig_a, tanh_a, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
